on_the_fly_table: RTL and testbench

ON_THE_FLY_TABLE -- requirements
Module: on_the_fly_table

---
 rtl/on_the_fly_table_pkg.sv | 25 ++
 rtl/on_the_fly_table_priority.sv | 25 ++
 rtl/on_the_fly_table.sv | 147 ++++++++++++++
 tb/tb_on_the_fly_table.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/on_the_fly_table_pkg.sv
// Shared types for the on-the-fly transaction table; also carries the NIC flit-field
// width defaults (normally from NIC-defines.v) and leaves OTF_TIMEOUT_EN undefined by default.
`ifndef N_BIT_SRC_HEAD_FLIT
`define N_BIT_SRC_HEAD_FLIT 4
`endif
`ifndef N_BIT_DEST_HEAD_FLIT
`define N_BIT_DEST_HEAD_FLIT 4
`endif
`ifndef N_BIT_CMD_HEAD_FLIT
`define N_BIT_CMD_HEAD_FLIT 4
`endif

package on_the_fly_table_pkg;

   localparam int OTF_SRC_W  = `N_BIT_SRC_HEAD_FLIT;
   localparam int OTF_DEST_W = `N_BIT_DEST_HEAD_FLIT;
   localparam int OTF_CMD_W  = `N_BIT_CMD_HEAD_FLIT;

   typedef struct packed {
      logic [OTF_SRC_W-1:0]  sender;
      logic [OTF_DEST_W-1:0] recipient;
      logic [OTF_CMD_W-1:0]  cmd;
   } otf_tuple_t;

endpackage

// File: rtl/on_the_fly_table_priority.sv
// Lowest-index-first priority encoder: index of the lowest set request bit plus a found flag.
module otf_priority_encoder #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   // scan downwards so the lowest set bit is the last one written
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = W'(i);
            found_o = 1'b1;
         end else begin
            idx_o   = idx_o;
         end
      end
   end

endmodule

// File: rtl/on_the_fly_table.sv
// Table of outstanding NoC transactions with lookup/retire; optional per-entry expiry
// is built when OTF_TIMEOUT_EN is defined.
module on_the_fly_table
   import on_the_fly_table_pkg::*;
#(
   parameter int N_ENTRIES      = 8,
   parameter int N_BITS_POINTER = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          insert_i,
   input  logic [`N_BIT_SRC_HEAD_FLIT-1:0]  insert_sender_i,
   input  logic [`N_BIT_DEST_HEAD_FLIT-1:0] insert_recipient_i,
   input  logic [`N_BIT_CMD_HEAD_FLIT-1:0]  insert_type_i,
   input  logic                          query_i,
   input  logic [`N_BIT_SRC_HEAD_FLIT-1:0]  query_sender_i,
   input  logic [`N_BIT_DEST_HEAD_FLIT-1:0] query_recipient_i,
   input  logic [`N_BIT_CMD_HEAD_FLIT-1:0]  query_type_i,
   input  logic                          executed_i,
   output logic                          is_a_pending_transaction_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [N_BITS_POINTER:0]       count_o,
   output logic                          overflow_o,
   output logic                          timeout_o
);

   otf_tuple_t                entry_q [N_ENTRIES];
   otf_tuple_t                ins_tuple_s, qry_tuple_s;
   logic [N_ENTRIES-1:0]      valid_q, valid_d, match_s, free_s, retire_s, expire_s;
   logic                      hit_q, hit_d, pend_q, pend_d, ovf_q, ovf_d, to_q, to_d;
   logic [N_BITS_POINTER-1:0] hit_idx_q, hit_idx_d, ins_idx_s, match_idx_s;
   logic                      ins_found_s, match_found_s, ins_ok_s;
   logic [N_BITS_POINTER:0]   count_q, count_d;
   logic                      full_q, empty_q;

   function automatic logic [N_BITS_POINTER:0] popcount(input logic [N_ENTRIES-1:0] v);
      logic [N_BITS_POINTER:0] c;
      c = '0;
      for (int i = 0; i < N_ENTRIES; i++) c = c + {{N_BITS_POINTER{1'b0}}, v[i]};
      return c;
   endfunction

   assign ins_tuple_s = '{sender: insert_sender_i, recipient: insert_recipient_i, cmd: insert_type_i};
   assign qry_tuple_s = '{sender: query_sender_i, recipient: query_recipient_i, cmd: query_type_i};

   // Entries leaving this cycle are excluded from the lookup so a hit never names a dying slot;
   // a full table may refill a slot freed in the same cycle.
   always_comb begin
      retire_s = '0;
      if (executed_i && hit_q) retire_s[hit_idx_q] = 1'b1;
      else                     retire_s = '0;
      for (int i = 0; i < N_ENTRIES; i++)
         match_s[i] = valid_q[i] & ~retire_s[i] & ~expire_s[i] & (entry_q[i] == qry_tuple_s);
      free_s = (&valid_q) ? (retire_s | expire_s) : ~valid_q;
   end

   otf_priority_encoder #(.N(N_ENTRIES), .W(N_BITS_POINTER)) u_free_enc (
      .req_i(free_s), .idx_o(ins_idx_s), .found_o(ins_found_s));

   otf_priority_encoder #(.N(N_ENTRIES), .W(N_BITS_POINTER)) u_match_enc (
      .req_i(match_s), .idx_o(match_idx_s), .found_o(match_found_s));

   assign ins_ok_s = insert_i & ins_found_s;

   // next-state for valid bits, hit latch and pulses
   always_comb begin
      valid_d = valid_q & ~retire_s & ~expire_s;
      if (ins_ok_s) valid_d[ins_idx_s] = 1'b1;
      else          valid_d = valid_d;
      if (query_i) begin
         hit_d     = match_found_s;
         hit_idx_d = match_idx_s;
      end else if (retire_s[hit_idx_q] || expire_s[hit_idx_q]) begin
         hit_d     = 1'b0;
         hit_idx_d = hit_idx_q;
      end else begin
         hit_d     = hit_q;
         hit_idx_d = hit_idx_q;
      end
      pend_d  = query_i & match_found_s;
      ovf_d   = insert_i & ~ins_found_s;
      count_d = popcount(valid_d);
   end

`ifdef OTF_TIMEOUT_EN
   localparam int AGE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [AGE_W-1:0] age_q [N_ENTRIES];

   always_comb begin
      for (int i = 0; i < N_ENTRIES; i++)
         expire_s[i] = valid_q[i] & (age_q[i] == AGE_W'(TIMEOUT_CYCLES - 1));
      to_d = |expire_s;
   end

   // ages restart on insert and advance every cycle an entry is live
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (rst)                                               age_q[i] <= '0;
         else if (ins_ok_s && (ins_idx_s == N_BITS_POINTER'(i))) age_q[i] <= '0;
         else if (valid_q[i])                                   age_q[i] <= age_q[i] + AGE_W'(1);
         else                                                   age_q[i] <= age_q[i];
      end
   end
`else
   assign expire_s = '0;
   assign to_d     = 1'b0;
`endif

   // tuple storage needs no reset: valid bits gate every use
   always_ff @(posedge clk) begin
      if (ins_ok_s) entry_q[ins_idx_s] <= ins_tuple_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= '0;
         hit_q     <= 1'b0;
         hit_idx_q <= '0;
         pend_q    <= 1'b0;
         ovf_q     <= 1'b0;
         to_q      <= 1'b0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         valid_q   <= valid_d;
         hit_q     <= hit_d;
         hit_idx_q <= hit_idx_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         to_q      <= to_d;
         count_q   <= count_d;
         full_q    <= (count_d == (N_BITS_POINTER + 1)'(N_ENTRIES));
         empty_q   <= (count_d == '0);
      end
   end

   assign is_a_pending_transaction_o = pend_q;
   assign full_o                     = full_q;
   assign empty_o                    = empty_q;
   assign count_o                    = count_q;
   assign overflow_o                 = ovf_q;
   assign timeout_o                  = to_q;

endmodule

// File: tb/tb_on_the_fly_table.sv
// Directed self-checking bench for on_the_fly_table; the timeout scenario runs only when
// OTF_TIMEOUT_EN is defined, otherwise timeout_o is checked to stay low.
module tb_on_the_fly_table;

   logic       clk = 1'b0;
   logic       rst, insert_i, query_i, executed_i;
   logic [`N_BIT_SRC_HEAD_FLIT-1:0]  ins_s, qry_s;
   logic [`N_BIT_DEST_HEAD_FLIT-1:0] ins_r, qry_r;
   logic [`N_BIT_CMD_HEAD_FLIT-1:0]  ins_t, qry_t;
   logic       pend_o, full_o, empty_o, overflow_o, timeout_o;
   logic [3:0] count_o;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   on_the_fly_table #(.N_ENTRIES(8), .N_BITS_POINTER(3), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .insert_i(insert_i), .insert_sender_i(ins_s), .insert_recipient_i(ins_r), .insert_type_i(ins_t),
      .query_i(query_i), .query_sender_i(qry_s), .query_recipient_i(qry_r), .query_type_i(qry_t),
      .executed_i(executed_i), .is_a_pending_transaction_o(pend_o),
      .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
      .overflow_o(overflow_o), .timeout_o(timeout_o));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rst = 1'b0; insert_i = 1'b0; query_i = 1'b0; executed_i = 1'b0;
   endtask

   task automatic set_ins(input int s, input int r, input int t);
      insert_i = 1'b1; ins_s = 4'(s); ins_r = 4'(r); ins_t = 4'(t);
   endtask

   task automatic set_qry(input int s, input int r, input int t);
      query_i = 1'b1; qry_s = 4'(s); qry_r = 4'(r); qry_t = 4'(t);
   endtask

   initial begin
      rst = 1'b1; insert_i = 1'b0; query_i = 1'b0; executed_i = 1'b0;
      ins_s = '0; ins_r = '0; ins_t = '0; qry_s = '0; qry_r = '0; qry_t = '0;
      tick();
      check("rst_pend", pend_o, 0);
      check("rst_full", full_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_count", count_o, 0);
      check("rst_ovf", overflow_o, 0);
      check("rst_to", timeout_o, 0);

      // basic insert / query / retire
      set_ins(2, 5, 3); tick();
      check("ins1_count", count_o, 1);
      check("ins1_empty", empty_o, 0);
      set_qry(2, 5, 3); tick();
      check("q1_hit", pend_o, 1);
      tick();
      check("q1_pulse", pend_o, 0);
      set_qry(2, 5, 4); tick();
      check("q_miss_type", pend_o, 0);
      executed_i = 1'b1; tick();
      check("exec_nohit_count", count_o, 1);
      set_qry(2, 5, 3); tick();
      check("q2_hit", pend_o, 1);
      executed_i = 1'b1; tick();
      check("exec_count", count_o, 0);
      check("exec_empty", empty_o, 1);
      set_qry(2, 5, 3); tick();
      check("q_after_exec", pend_o, 0);

      // same-cycle insert and query do not see each other
      set_ins(7, 7, 7); set_qry(7, 7, 7); tick();
      check("insq_pend", pend_o, 0);
      check("insq_count", count_o, 1);
      rst = 1'b1; tick();
      check("rst2_count", count_o, 0);

      // fill, overflow, retire+insert into the freed slot
      for (int i = 0; i < 8; i++) begin
         set_ins(i, 1, 0); tick();
      end
      check("fill_count", count_o, 8);
      check("fill_full", full_o, 1);
      check("fill_ovf", overflow_o, 0);
      set_ins(15, 15, 15); tick();
      check("ovf_pulse", overflow_o, 1);
      check("ovf_count", count_o, 8);
      tick();
      check("ovf_clear", overflow_o, 0);
      set_qry(15, 15, 15); tick();
      check("dropped_absent", pend_o, 0);
      set_qry(3, 1, 0); tick();
      check("q_slot3", pend_o, 1);
      executed_i = 1'b1; set_ins(9, 9, 9); tick();
      check("swap_count", count_o, 8);
      check("swap_full", full_o, 1);
      check("swap_ovf", overflow_o, 0);
      set_qry(9, 9, 9); tick();
      check("q_new", pend_o, 1);
      set_qry(3, 1, 0); tick();
      check("q_retired", pend_o, 0);
      rst = 1'b1; tick();

      // duplicates: lowest index retired first
      set_ins(1, 2, 3); tick();
      set_ins(1, 2, 3); tick();
      check("dup_count", count_o, 2);
      set_qry(1, 2, 3); tick();
      check("dup_q1", pend_o, 1);
      executed_i = 1'b1; tick();
      check("dup_exec1", count_o, 1);
      set_qry(1, 2, 3); tick();
      check("dup_q2", pend_o, 1);
      executed_i = 1'b1; tick();
      check("dup_exec2", count_o, 0);
      set_qry(1, 2, 3); tick();
      check("dup_q3", pend_o, 0);

      // retire and re-query in one cycle picks up the surviving duplicate
      set_ins(4, 4, 4); tick();
      set_ins(4, 4, 4); tick();
      set_qry(4, 4, 4); tick();
      executed_i = 1'b1; set_qry(4, 4, 4); tick();
      check("eq_pend", pend_o, 1);
      check("eq_count", count_o, 1);
      executed_i = 1'b1; tick();
      check("eq_exec", count_o, 0);

      // reset beats concurrent insert/query/execute
      for (int i = 0; i < 3; i++) begin
         set_ins(i, 3, 3); tick();
      end
      set_qry(0, 3, 3); tick();
      check("pre_rst_count", count_o, 3);
      rst = 1'b1; set_ins(5, 5, 5); executed_i = 1'b1; set_qry(1, 3, 3); tick();
      check("rstp_count", count_o, 0);
      check("rstp_empty", empty_o, 1);
      check("rstp_pend", pend_o, 0);
      check("rstp_ovf", overflow_o, 0);
      check("rstp_to", timeout_o, 0);
      set_qry(1, 3, 3); tick();
      check("rstp_q", pend_o, 0);

`ifdef OTF_TIMEOUT_EN
      set_ins(6, 6, 6); tick();
      set_qry(6, 6, 6); tick();
      check("to_hit", pend_o, 1);
      for (int i = 0; i < 14; i++) tick();
      check("to_early", timeout_o, 0);
      check("to_early_count", count_o, 1);
      tick();
      check("to_pulse", timeout_o, 1);
      check("to_count", count_o, 0);
      tick();
      check("to_pulse_end", timeout_o, 0);
      set_ins(6, 6, 6); tick();
      executed_i = 1'b1; tick();
      check("to_exec_ignored", count_o, 1);
`else
      set_ins(6, 6, 6); tick();
      for (int i = 0; i < 20; i++) tick();
      check("no_to", timeout_o, 0);
      check("no_to_count", count_o, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
